// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory request at a time, holds the
// returned word for decode, and handles redirects, flushes and misaligned targets.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [2:0]  dbg_state
);

  // Handshakes: memory transfer completes in a cycle with imem_req=1 and imem_ack=1;
  // decode transfer completes in a cycle with instr_valid=1 and stall=0.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_HOLD    = 3'd2,
    S_DISCARD = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        bad_target;

  assign bad_target = redirect && (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    if (bad_target) begin
      // A misaligned target is fatal from any state; pc keeps its old value.
      state_d       = S_FAULT;
      fault_d       = 1'b1;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          if (redirect) begin
            pc_d         = redirect_target;
            fetch_addr_d = redirect_target;
          end else begin
            fetch_addr_d = pc_q;
          end
        end
        S_FETCH: begin
          if (redirect) begin
            pc_d = redirect_target;
            if (imem_ack) fetch_addr_d = redirect_target;
            else          state_d      = S_DISCARD;
          end else if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_pc_d    = fetch_addr_q;
            pc_d          = fetch_addr_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
        S_HOLD: begin
          // Redirect flushes the held word even if decode accepts it this cycle.
          if (redirect) begin
            instr_valid_d = 1'b0;
            pc_d          = redirect_target;
            fetch_addr_d  = redirect_target;
            state_d       = S_FETCH;
          end else if (!stall) begin
            instr_valid_d = 1'b0;
            fetch_count_d = fetch_count_q + 32'd1;
            fetch_addr_d  = pc_q;
            state_d       = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (redirect) pc_d = redirect_target;
          if (imem_ack) begin
            fetch_addr_d = redirect ? redirect_target : pc_q;
            state_d      = S_FETCH;
          end
        end
        default: begin
          instr_valid_d = 1'b0;
        end
      endcase
    end
    imem_req_d = (state_d == S_FETCH) || (state_d == S_DISCARD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      fault_q       <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = fetch_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory responder, decode driver and a
// scoreboard of expected {pc, instr} pairs popped on every decode accept.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] fetch_count;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  logic ack_en = 1'b1;
  logic nop_data = 1'b1;
  logic [63:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] held_instr;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fault(fault), .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return nop_data ? 32'h0000_0013 : (a ^ 32'hCAFE_0000);
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // One clock: drive responder, score accepts, check address stability.
  task automatic tick();
    logic [63:0] e;
    logic        was_pending;
    logic [31:0] prev_addr;
    imem_ack   = ack_en && imem_req;
    imem_rdata = mem_word(imem_addr);
    if (imem_req && imem_ack && addr_q.size() > 0)
      check_val("imem_addr_seq", imem_addr, addr_q.pop_front());
    if (instr_valid && !stall && !redirect) begin
      accepts++;
      if (exp_q.size() == 0) check_val("unexpected_accept", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check_val("instr_pc", instr_pc, e[63:32]);
        check_val("instr", instr, e[31:0]);
      end
    end
    was_pending = imem_req && !imem_ack;
    prev_addr   = imem_addr;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if (was_pending && imem_req) check_val("addr_stable", imem_addr, prev_addr);
  endtask

  task automatic run_accepts(input int n);
    int target = accepts + n;
    int budget = 200;
    while (accepts < target && budget > 0) begin
      tick();
      budget--;
    end
    if (accepts < target) check_val("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect        = 1'b1;
    redirect_target = tgt;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_req", imem_req, 1'b0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_valid", instr_valid, 1'b0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_pc", instr_pc, 32'h0);
    check_val("rst_fault", fault, 1'b0);
    check_val("rst_count", fetch_count, 32'h0);
    exp_q.delete();
    addr_q.delete();
    stall = 1'b0; redirect = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Straight-line fetch of three NOPs.
    nop_data = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(32'(i * 4));
      addr_q.push_back(32'(i * 4));
    end
    run_accepts(3);
    check_val("count_after_3", fetch_count, 32'd3);

    // Stall in HOLD at pc 0x4.
    nop_data = 1'b0;
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    run_accepts(1);
    stall = 1'b1;
    tick();
    held_instr = instr;
    check_val("hold_pc", instr_pc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", instr_valid, 1'b1);
      check_val("hold_instr", instr, held_instr);
      check_val("hold_count", fetch_count, 32'd1);
      check_val("hold_req", imem_req, 1'b0);
      if (i < 4) tick();
    end

    // Release stall with ack withheld, then redirect while the fetch is outstanding.
    stall  = 1'b0;
    ack_en = 1'b0;
    tick();
    check_val("fetch8_req", imem_req, 1'b1);
    check_val("fetch8_addr", imem_addr, 32'h8);
    pulse_redirect(32'h100);
    for (int i = 0; i < 2; i++) begin
      check_val("discard_addr", imem_addr, 32'h8);
      check_val("discard_valid", instr_valid, 1'b0);
      tick();
    end
    ack_en = 1'b1;
    addr_q.push_back(32'h8);
    addr_q.push_back(32'h100);
    tick();
    check_val("post_discard_valid", instr_valid, 1'b0);
    check_val("post_discard_addr", imem_addr, 32'h100);
    push_exp(32'h100);
    run_accepts(1);
    check_val("count_after_100", fetch_count, 32'd3);

    // Redirect in HOLD with stall=0 flushes the word.
    tick();
    check_val("hold104_valid", instr_valid, 1'b1);
    check_val("hold104_pc", instr_pc, 32'h104);
    pulse_redirect(32'h200);
    check_val("flush_valid", instr_valid, 1'b0);
    check_val("flush_count", fetch_count, 32'd3);
    check_val("flush_addr", imem_addr, 32'h200);
    push_exp(32'h200);
    run_accepts(1);
    check_val("count_after_200", fetch_count, 32'd4);

    // Redirect coincident with ack in FETCH drops the word and refetches at target.
    check_val("fetch204_addr", imem_addr, 32'h204);
    pulse_redirect(32'h300);
    check_val("redir_ack_valid", instr_valid, 1'b0);
    check_val("redir_ack_addr", imem_addr, 32'h300);
    check_val("redir_ack_req", imem_req, 1'b1);
    push_exp(32'h300);
    run_accepts(1);
    check_val("count_after_300", fetch_count, 32'd5);

    // Misaligned target: sticky fault until reset.
    pulse_redirect(32'h102);
    for (int i = 0; i < 6; i++) begin
      check_val("fault_flag", fault, 1'b1);
      check_val("fault_req", imem_req, 1'b0);
      check_val("fault_valid", instr_valid, 1'b0);
      if (i == 3) pulse_redirect(32'h400);
      else tick();
    end
    check_val("fault_count", fetch_count, 32'd5);
    do_reset();
    check_val("after_fault_rst", fault, 1'b0);
    push_exp(32'h0);
    run_accepts(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: The module SHALL have a parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002: clk  input  1  clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: imem_req  output  1  instruction memory request; address valid while high.
REQ-005: imem_addr  output  32  fetch address; held stable while imem_req=1 until imem_ack.
REQ-006: imem_ack  input  1  memory completion; imem_rdata is valid in the same cycle; ignored while imem_req=0.
REQ-007: imem_rdata  input  32  fetched instruction word.
REQ-008: stall  input  1  decode not ready; handshake completes when instr_valid=1 and stall=0.
REQ-009: redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-010: redirect_target  input  32  new PC, sampled when redirect=1.
REQ-011: instr_valid  output  1  instr/instr_pc valid.
REQ-012: instr  output  32  captured instruction.
REQ-013: instr_pc  output  32  address of instr.
REQ-014: fault  output  1  sticky misaligned-target flag.
REQ-015: fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-016: The module SHALL implement the states IDLE, FETCH, HOLD, DISCARD and FAULT, with registers pc (next fetch address) and fetch_addr (driving imem_addr).
REQ-017: IDLE: imem_req=0; unconditionally go to FETCH next cycle with fetch_addr=pc.
REQ-018: FETCH: imem_req=1.
  - imem_ack=1 and redirect=0: capture instr=imem_rdata and instr_pc=fetch_addr; set pc=fetch_addr+4 (mod 2^32); instr_valid=1; go to HOLD.
REQ-019: FETCH, redirect=1 with imem_ack=1: drop the returned word (instr_valid stays 0); pc=fetch_addr=redirect_target; stay in FETCH.
REQ-020: FETCH, redirect=1 with imem_ack=0: pc=redirect_target; fetch_addr unchanged; go to DISCARD.
REQ-021: HOLD: imem_req=0; instr_valid=1.
  - stall=0: instr_valid=0 next cycle; fetch_count+1 (wraps at 2^32); fetch_addr=pc; go to FETCH.
  - stall=1: hold all outputs unchanged.
REQ-022: HOLD, redirect=1: the instruction SHALL be flushed (instr_valid=0 next cycle, fetch_count unchanged even if stall=0); pc=fetch_addr=redirect_target; go to FETCH. Redirect has priority over accept.
REQ-023: DISCARD: imem_req=1 with old fetch_addr.
  - imem_ack=1: discard data; fetch_addr=pc; go to FETCH.
  - redirect=1: pc=redirect_target (newest wins); if imem_ack=1 in the same cycle, fetch_addr=redirect_target.
REQ-024: A redirect with redirect_target[1:0]!=0 in any state SHALL set fault=1, force instr_valid=0 and go to FAULT; pc is not updated.
REQ-025: FAULT: imem_req=0, instr_valid=0; absorbing until rst.
REQ-026: Steady-state throughput SHALL be at most one instruction per two cycles, with one cycle of ack latency.
REQ-027: imem_addr SHALL never change while imem_req=1 and imem_ack=0.

Reset
REQ-028: On rst assertion, the module SHALL immediately enter IDLE with pc=fetch_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0, fetch_count=0.
REQ-029: Reset asserted mid-transaction SHALL abandon it; a late imem_ack is ignored while imem_req=0.

Verification
REQ-030: Release reset; ack every request with rdata=0x00000013, stall=0 -> imem_addr sequence 0,4,8; instr_pc=0,4,8; fetch_count=3 after the third accept.
REQ-031: In HOLD with instr_pc=0x4, hold stall=1 for 5 cycles -> instr_valid=1 and instr stable for all 5 cycles, fetch_count unchanged; drop stall -> next imem_addr=0x8.
REQ-032: In FETCH at 0x8 with ack withheld, pulse redirect to 0x100 -> imem_addr stays 0x8 until ack, that data is dropped, next imem_addr=0x100.
REQ-033: In HOLD with stall=0, pulse redirect to 0x200 -> instr_valid=0 next cycle, fetch_count unchanged, next imem_addr=0x200.
REQ-034: Pulse redirect to 0x102 -> fault=1, imem_req=0 permanently; assert rst -> fault=0, imem_addr=RESET_PC.
